// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit:
// opcode values, FSM state encoding, accumulator source selects and the
// default PC/RAM address width.
package cpu_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_LDR  = 4'h5;
    localparam logic [3:0] OP_STR  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JPOS = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOADIR = 3'd2,
        ST_DECODE = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] ASRC_MEM = 2'b00;
    localparam logic [1:0] ASRC_ALU = 2'b01;
    localparam logic [1:0] ASRC_RF  = 2'b10;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Combinational opcode classifier for the control FSM.
// Ports:
//   opcode     in  4  instruction opcode (IR[15:8] bits [7:4])
//   is_mem_rd  out 1  LDA / ADD / SUB (RAM operand read, then write-back)
//   is_store   out 1  STA / STR
//   is_rf      out 1  LDR / STR (register-file access)
//   is_jump    out 1  JMP / JZ / JPOS
//   is_halt    out 1  HALT
//   is_illegal out 1  opcodes A..E
// STA = store & ~rf, STR = store & rf, LDR = rf & ~store.
module cpu_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_mem_rd,
    output logic       is_store,
    output logic       is_rf,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        is_mem_rd  = 1'b0;
        is_store   = 1'b0;
        is_rf      = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:                 ;
            OP_LDA, OP_ADD, OP_SUB: is_mem_rd = 1'b1;
            OP_STA:                 is_store  = 1'b1;
            OP_LDR:                 is_rf     = 1'b1;
            OP_STR: begin
                is_store = 1'b1;
                is_rf    = 1'b1;
            end
            OP_JMP, OP_JZ, OP_JPOS: is_jump   = 1'b1;
            OP_HALT:                is_halt   = 1'b1;
            default:                is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Moore-style sequencer for the accumulator CPU datapath
// (fetch / load IR / decode / write-back, plus HALT).
// Ports:
//   clk, reset (async, active-low), run (allow fetch), opcode,
//   aeq0 / apos (accumulator flags, sampled in DECODE);
//   pc_clear, ir_clear, a_clear, pc_load, pc_src, ir_load, mem_addr_sel,
//   mem_we, rf_we, a_load, a_src, alu_sub: datapath controls;
//   instr_done, illegal, halted: status.
// Outputs are decoded from the state register and the opcode, so an
// asynchronous reset forces INIT outputs immediately.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
    parameter bit          HALT_ON_ILLEGAL = 1'b0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       aeq0,
    input  logic       apos,
    output logic       pc_clear,
    output logic       ir_clear,
    output logic       a_clear,
    output logic       pc_load,
    output logic       pc_src,
    output logic       ir_load,
    output logic       mem_addr_sel,
    output logic       mem_we,
    output logic       rf_we,
    output logic       a_load,
    output logic [1:0] a_src,
    output logic       alu_sub,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted
);

    // ADDR_W only sizes the datapath; reject a degenerate width here.
    if (ADDR_W == 0) begin : g_addr_w_check
        $error("cpu_control_unit: ADDR_W must be at least 1");
    end

    state_t state;
    logic   is_mem_rd, is_store, is_rf, is_jump, is_halt, is_illegal;

    cpu_opcode_decode u_decode (
        .opcode     (opcode),
        .is_mem_rd  (is_mem_rd),
        .is_store   (is_store),
        .is_rf      (is_rf),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT:   state <= ST_FETCH;
                ST_FETCH:  if (run) state <= ST_LOADIR;
                ST_LOADIR: state <= ST_DECODE;
                ST_DECODE: begin
                    if (is_halt || (is_illegal && HALT_ON_ILLEGAL))
                        state <= ST_HALT;
                    else if (is_mem_rd || (is_rf && !is_store))
                        state <= ST_WB;
                    else
                        state <= ST_FETCH;
                end
                ST_WB:     state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        pc_clear     = 1'b0;
        ir_clear     = 1'b0;
        a_clear      = 1'b0;
        pc_load      = 1'b0;
        pc_src       = 1'b0;
        ir_load      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        rf_we        = 1'b0;
        a_load       = 1'b0;
        a_src        = ASRC_MEM;
        alu_sub      = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        halted       = 1'b0;
        case (state)
            ST_INIT: begin
                pc_clear = 1'b1;
                ir_clear = 1'b1;
                a_clear  = 1'b1;
            end
            ST_FETCH: ;
            ST_LOADIR: begin
                ir_load = 1'b1;
                pc_load = 1'b1;
            end
            ST_DECODE: begin
                if (is_mem_rd) begin
                    mem_addr_sel = 1'b1;
                end else if (is_store && !is_rf) begin
                    mem_addr_sel = 1'b1;
                    mem_we       = 1'b1;
                    instr_done   = 1'b1;
                end else if (is_store && is_rf) begin
                    rf_we      = 1'b1;
                    instr_done = 1'b1;
                end else if (is_rf) begin
                    // LDR: register file read only, A loads in WB
                end else if (is_jump) begin
                    pc_src     = 1'b1;
                    pc_load    = (opcode == OP_JMP)
                               | ((opcode == OP_JZ)   & aeq0)
                               | ((opcode == OP_JPOS) & apos);
                    instr_done = 1'b1;
                end else if (is_illegal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    instr_done = 1'b1;
                end
            end
            ST_WB: begin
                a_load     = 1'b1;
                instr_done = 1'b1;
                case (opcode)
                    OP_LDR:         a_src = ASRC_RF;
                    OP_ADD, OP_SUB: begin
                        a_src   = ASRC_ALU;
                        alu_sub = (opcode == OP_SUB);
                    end
                    default:        a_src = ASRC_MEM;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
    import cpu_ctrl_pkg::*;

    // Output vector bit positions
    localparam logic [15:0] B_PCLR = 16'h8000;
    localparam logic [15:0] B_ICLR = 16'h4000;
    localparam logic [15:0] B_ACLR = 16'h2000;
    localparam logic [15:0] B_PCLD = 16'h1000;
    localparam logic [15:0] B_PSRC = 16'h0800;
    localparam logic [15:0] B_IRLD = 16'h0400;
    localparam logic [15:0] B_MAS  = 16'h0200;
    localparam logic [15:0] B_MWE  = 16'h0100;
    localparam logic [15:0] B_RWE  = 16'h0080;
    localparam logic [15:0] B_ALD  = 16'h0040;
    localparam logic [15:0] B_ARF  = 16'h0020;
    localparam logic [15:0] B_AALU = 16'h0010;
    localparam logic [15:0] B_SUB  = 16'h0008;
    localparam logic [15:0] B_DONE = 16'h0004;
    localparam logic [15:0] B_ILL  = 16'h0002;
    localparam logic [15:0] B_HLT  = 16'h0001;

    localparam logic [15:0] E_CLR    = B_PCLR | B_ICLR | B_ACLR;
    localparam logic [15:0] E_FETCH  = 16'h0000;
    localparam logic [15:0] E_LOADIR = B_IRLD | B_PCLD;
    localparam logic [15:0] E_HALT   = B_HLT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       aeq0 = 1'b0;
    logic       apos = 1'b0;

    logic pc_clear0, ir_clear0, a_clear0, pc_load0, pc_src0, ir_load0, mas0, mem_we0;
    logic rf_we0, a_load0, alu_sub0, done0, illegal0, halted0;
    logic [1:0] a_src0;
    logic pc_clear1, ir_clear1, a_clear1, pc_load1, pc_src1, ir_load1, mas1, mem_we1;
    logic rf_we1, a_load1, alu_sub1, done1, illegal1, halted1;
    logic [1:0] a_src1;
    logic [15:0] outs0, outs1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(.ADDR_W(6), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .aeq0(aeq0), .apos(apos),
        .pc_clear(pc_clear0), .ir_clear(ir_clear0), .a_clear(a_clear0),
        .pc_load(pc_load0), .pc_src(pc_src0), .ir_load(ir_load0),
        .mem_addr_sel(mas0), .mem_we(mem_we0), .rf_we(rf_we0),
        .a_load(a_load0), .a_src(a_src0), .alu_sub(alu_sub0),
        .instr_done(done0), .illegal(illegal0), .halted(halted0)
    );

    cpu_control_unit #(.ADDR_W(6), .HALT_ON_ILLEGAL(1'b1)) dut_hlt (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .aeq0(aeq0), .apos(apos),
        .pc_clear(pc_clear1), .ir_clear(ir_clear1), .a_clear(a_clear1),
        .pc_load(pc_load1), .pc_src(pc_src1), .ir_load(ir_load1),
        .mem_addr_sel(mas1), .mem_we(mem_we1), .rf_we(rf_we1),
        .a_load(a_load1), .a_src(a_src1), .alu_sub(alu_sub1),
        .instr_done(done1), .illegal(illegal1), .halted(halted1)
    );

    assign outs0 = {pc_clear0, ir_clear0, a_clear0, pc_load0, pc_src0, ir_load0, mas0,
                    mem_we0, rf_we0, a_load0, a_src0, alu_sub0, done0, illegal0, halted0};
    assign outs1 = {pc_clear1, ir_clear1, a_clear1, pc_load1, pc_src1, ir_load1, mas1,
                    mem_we1, rf_we1, a_load1, a_src1, alu_sub1, done1, illegal1, halted1};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_both(input string tag, input logic [15:0] exp);
        check({tag, "/nop"}, outs0, exp);
        check({tag, "/hlt"}, outs1, exp);
    endtask

    // Advance one cycle; sample point is 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH with run = 1; ends in the following FETCH.
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic [15:0] e_dec, input bit has_wb,
                             input logic [15:0] e_wb);
        opcode = op;
        check_both({tag, "_fetch"}, E_FETCH);
        step();
        check_both({tag, "_loadir"}, E_LOADIR);
        step();
        check_both({tag, "_decode"}, e_dec);
        if (has_wb) begin
            step();
            check_both({tag, "_wb"}, e_wb);
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset held low for 3 cycles, then INIT -> FETCH -> LOADIR
        #1;
        check_both("reset_async", E_CLR);
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("reset_hold", E_CLR);
        end
        reset = 1'b1;
        check_both("init", E_CLR);
        step();

        // 2. write-back instructions (4 cycles each)
        run_instr("lda", OP_LDA, B_MAS, 1'b1, B_ALD | B_DONE);
        run_instr("sub", OP_SUB, B_MAS, 1'b1, B_ALD | B_AALU | B_SUB | B_DONE);
        run_instr("add", OP_ADD, B_MAS, 1'b1, B_ALD | B_AALU | B_DONE);
        run_instr("ldr", OP_LDR, 16'h0000, 1'b1, B_ALD | B_ARF | B_DONE);

        // 3. jumps (3 cycles each); flags sampled in DECODE
        aeq0 = 1'b1; apos = 1'b0;
        run_instr("jz_taken", OP_JZ, B_PCLD | B_PSRC | B_DONE, 1'b0, 16'h0000);
        aeq0 = 1'b0; apos = 1'b1;
        run_instr("jz_not", OP_JZ, B_PSRC | B_DONE, 1'b0, 16'h0000);
        run_instr("jpos_taken", OP_JPOS, B_PCLD | B_PSRC | B_DONE, 1'b0, 16'h0000);
        aeq0 = 1'b1; apos = 1'b0;
        run_instr("jpos_not", OP_JPOS, B_PSRC | B_DONE, 1'b0, 16'h0000);
        run_instr("jmp", OP_JMP, B_PCLD | B_PSRC | B_DONE, 1'b0, 16'h0000);
        run_instr("nop", OP_NOP, B_DONE, 1'b0, 16'h0000);

        // 4. stores, then reset in the STA DECODE cycle
        run_instr("sta", OP_STA, B_MAS | B_MWE | B_DONE, 1'b0, 16'h0000);
        run_instr("str", OP_STR, B_RWE | B_DONE, 1'b0, 16'h0000);
        opcode = OP_STA;
        check_both("sta2_fetch", E_FETCH);
        step();
        check_both("sta2_loadir", E_LOADIR);
        step();
        check_both("sta2_decode", B_MAS | B_MWE | B_DONE);
        reset = 1'b0;
        #1;
        check_both("sta2_async_rst", E_CLR);
        step();
        check_both("sta2_rst_hold", E_CLR);
        reset = 1'b1;
        step();

        // 6a. run low stalls in FETCH
        run = 1'b0;
        opcode = OP_LDA;
        for (int i = 0; i < 5; i++) begin
            check_both("stall", E_FETCH);
            step();
        end
        run = 1'b1;
        run_instr("after_stall", OP_NOP, B_DONE, 1'b0, 16'h0000);

        // 6b. illegal opcode: both pulse illegal, only dut_hlt halts
        opcode = 4'hA;
        check_both("ill_fetch", E_FETCH);
        step();
        check_both("ill_loadir", E_LOADIR);
        step();
        check_both("ill_decode", B_ILL | B_DONE);
        step();
        check("ill_next/nop", outs0, E_FETCH);
        check("ill_next/hlt", outs1, E_HALT);

        // 5. HALT on dut_nop; dut_hlt must stay halted throughout
        opcode = OP_HALT;
        step();
        check("halt_loadir/nop", outs0, E_LOADIR);
        check("halt_loadir/hlt", outs1, E_HALT);
        step();
        check("halt_decode/nop", outs0, B_DONE);
        check("halt_decode/hlt", outs1, E_HALT);
        for (int i = 0; i < 100; i++) begin
            step();
            check_both("halted", E_HALT);
            run = i[0];
            opcode = 4'($urandom_range(0, 15));
        end
        reset = 1'b0;
        #1;
        check_both("halt_rst_async", E_CLR);
        step();
        run = 1'b1;
        reset = 1'b1;
        check_both("halt_rst_init", E_CLR);
        step();
        run_instr("recover_lda", OP_LDA, B_MAS, 1'b1, B_ALD | B_DONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
